// File: rtl/sfm_emu_pkg.sv
// Shared constants and state encoding for the serial-flash responder.
package sfm_emu_pkg;

   localparam logic [7:0] OP_READ = 8'h03;
   localparam logic [7:0] OP_PROG = 8'h82;
   localparam logic [7:0] OP_STAT = 8'hD7;

   typedef enum logic [2:0] {
      StIdle,
      StCmd,
      StAddr,
      StRead,
      StProg,
      StStat,
      StIgnore
   } sfm_state_e;

   localparam int unsigned STAT_RDY_BIT = 7;
   localparam int unsigned STAT_WP_BIT  = 6;

   function automatic logic [7:0] status_byte(input logic busy, input logic wp_b);
      logic [7:0] s;
      s               = 8'h00;
      s[STAT_RDY_BIT] = ~busy;
      s[STAT_WP_BIT]  = wp_b;
      return s;
   endfunction

endpackage

// File: rtl/sfm_emu_shifter.sv
// SCK edge detection, SI byte assembly and SO byte serialisation for the flash responder.
module sfm_emu_shifter (
   input  logic       CLKCMS,
   input  logic       RST_B,
   input  logic       clr,
   input  logic       SCK,
   input  logic       SI,
   input  logic       shift_en,
   input  logic       tx_step,
   input  logic [7:0] tx_byte,
   output logic       rise,
   output logic       fall,
   output logic       byte_done,
   output logic [7:0] rx_byte,
   output logic       tx_first,
   output logic       SO,
   output logic       SO_OE
);

   logic       sck_q;
   logic [6:0] rx_sr;
   logic [2:0] rx_cnt;
   logic [6:0] tx_sr;
   logic [2:0] tx_cnt;

   assign rise      = SCK & ~sck_q;
   assign fall      = ~SCK & sck_q;
   assign byte_done = shift_en & (rx_cnt == 3'd7);
   assign rx_byte   = {rx_sr, SI};
   assign tx_first  = (tx_cnt == 3'd0);

   always_ff @(posedge CLKCMS) begin
      if (!RST_B) begin
         sck_q  <= 1'b0;
         rx_sr  <= '0;
         rx_cnt <= '0;
         tx_sr  <= '0;
         tx_cnt <= '0;
         SO     <= 1'b0;
         SO_OE  <= 1'b0;
      end else begin
         sck_q <= SCK;
         if (clr) begin
            // Partial bytes in either direction are discarded.
            rx_cnt <= '0;
            tx_cnt <= '0;
            SO     <= 1'b0;
            SO_OE  <= 1'b0;
         end else begin
            if (shift_en) begin
               rx_sr  <= {rx_sr[5:0], SI};
               rx_cnt <= rx_cnt + 3'd1;
            end
            if (tx_step) begin
               if (tx_first) begin
                  SO    <= tx_byte[7];
                  tx_sr <= tx_byte[6:0];
               end else begin
                  SO    <= tx_sr[6];
                  tx_sr <= {tx_sr[5:0], 1'b0};
               end
               tx_cnt <= tx_cnt + 3'd1;
               SO_OE  <= 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/serfmem_emu.sv
// Serial-flash responder answering READ/PROGRAM/STATUS from a small byte array.
// Optional error counter built only when SFM_EMU_ERRCNT_EN is defined.
module serfmem_emu #(
   parameter int unsigned DEPTH       = 64,
   parameter int unsigned PROG_CYCLES = 256
) (
   input  logic       CLKCMS,
   input  logic       RST_B,
   input  logic       SCK,
   input  logic       CS_B,
   input  logic       SI,
   input  logic       WP_B,
   input  logic       FRST_B,
   output logic       SO,
   output logic       SO_OE,
   output logic       BUSY,
   output logic [7:0] ERRCNT
);
   import sfm_emu_pkg::*;

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(PROG_CYCLES + 1);

   sfm_state_e    state_q;
   logic [AW-1:0] addr_q;
   logic [1:0]    abyte_q;
   logic          is_prog_q, prog_any_q, prog_blk_q, busy_q;
   logic [CW-1:0] busy_cnt_q;
   logic [7:0]    mem [DEPTH];

   logic       clr, rise, fall, shift_en, tx_step, tx_first, tx_load, byte_done, mem_we;
   logic [7:0] rx_byte, tx_byte;

   assign clr      = CS_B | ~FRST_B;
   assign shift_en = rise & ~clr;
   assign tx_step  = fall & ~clr & ((state_q == StRead) | (state_q == StStat));
   assign tx_load  = tx_step & tx_first;
   // A PROGRAM decoded while busy stays blocked even if BUSY drops mid-command.
   assign mem_we   = byte_done & (state_q == StProg) & WP_B & ~busy_q & ~prog_blk_q;
   assign BUSY     = busy_q;

   always_comb begin
      tx_byte = 8'hFF;
      if (state_q == StStat)  tx_byte = status_byte(busy_q, WP_B);
      else if (!busy_q)       tx_byte = mem[addr_q];
   end

   sfm_emu_shifter u_shifter (
      .CLKCMS    (CLKCMS),
      .RST_B     (RST_B),
      .clr       (clr),
      .SCK       (SCK),
      .SI        (SI),
      .shift_en  (shift_en),
      .tx_step   (tx_step),
      .tx_byte   (tx_byte),
      .rise      (rise),
      .fall      (fall),
      .byte_done (byte_done),
      .rx_byte   (rx_byte),
      .tx_first  (tx_first),
      .SO        (SO),
      .SO_OE     (SO_OE)
   );

   always_ff @(posedge CLKCMS) begin
      if (!RST_B) begin
         for (int i = 0; i < int'(DEPTH); i++) mem[i] <= 8'hFF;
      end else if (mem_we) begin
         mem[addr_q] <= rx_byte;
      end
   end

   always_ff @(posedge CLKCMS) begin
      if (!RST_B) begin
         state_q    <= StIdle;
         addr_q     <= '0;
         abyte_q    <= '0;
         is_prog_q  <= 1'b0;
         prog_any_q <= 1'b0;
         prog_blk_q <= 1'b0;
         busy_q     <= 1'b0;
         busy_cnt_q <= '0;
      end else if (!FRST_B) begin
         state_q    <= StIdle;
         prog_any_q <= 1'b0;
         prog_blk_q <= 1'b0;
         busy_q     <= 1'b0;
         busy_cnt_q <= '0;
      end else begin
         if (busy_q) begin
            if (busy_cnt_q == '0) busy_q <= 1'b0;
            else                  busy_cnt_q <= busy_cnt_q - CW'(1);
         end
         if (CS_B) begin
            state_q <= StIdle;
            if ((state_q == StProg) && prog_any_q && !prog_blk_q) begin
               busy_q     <= 1'b1;
               busy_cnt_q <= CW'(PROG_CYCLES - 1);
            end
         end else begin
            case (state_q)
               StIdle: state_q <= StCmd;
               StCmd: begin
                  if (byte_done) begin
                     abyte_q    <= '0;
                     prog_any_q <= 1'b0;
                     prog_blk_q <= busy_q;
                     is_prog_q  <= (rx_byte == OP_PROG);
                     case (rx_byte)
                        OP_READ, OP_PROG: state_q <= StAddr;
                        OP_STAT:          state_q <= StStat;
                        default:          state_q <= StIgnore;
                     endcase
                  end
               end
               StAddr: begin
                  if (byte_done) begin
                     abyte_q <= abyte_q + 2'd1;
                     if (abyte_q == 2'd2) begin
                        addr_q  <= rx_byte[AW-1:0];
                        state_q <= is_prog_q ? StProg : StRead;
                     end
                  end
               end
               // Advancing on each byte load is equivalent to advancing after each 8th bit.
               StRead: if (tx_load) addr_q <= addr_q + AW'(1);
               StProg: begin
                  if (byte_done) begin
                     addr_q     <= addr_q + AW'(1);
                     prog_any_q <= 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

`ifdef SFM_EMU_ERRCNT_EN
   logic       err_evt;
   logic [7:0] errcnt_q;

   always_comb begin
      err_evt = 1'b0;
      if (FRST_B && CS_B) begin
         err_evt = (state_q == StCmd) | (state_q == StAddr) |
                   ((state_q == StProg) & ~prog_any_q);
      end else if (byte_done && (state_q == StCmd)) begin
         err_evt = ((rx_byte != OP_READ) && (rx_byte != OP_PROG) && (rx_byte != OP_STAT)) ||
                   ((rx_byte == OP_PROG) && busy_q);
      end
   end

   always_ff @(posedge CLKCMS) begin
      if (!RST_B)                             errcnt_q <= 8'h00;
      else if (err_evt && errcnt_q != 8'hFF)  errcnt_q <= errcnt_q + 8'd1;
   end

   assign ERRCNT = errcnt_q;
`else
   assign ERRCNT = 8'h00;
`endif

endmodule

// File: tb/tb_serfmem_emu.sv
// Randomised directed bench for serfmem_emu against a byte-array reference model.
module tb_serfmem_emu;

   localparam int PROG_CYCLES = 256;
`ifdef SFM_EMU_ERRCNT_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic CLKCMS = 1'b0, RST_B = 1'b0, SCK = 1'b0, CS_B = 1'b1, SI = 1'b0;
   logic WP_B = 1'b1, FRST_B = 1'b1;
   logic SO, SO_OE, BUSY;
   logic [7:0] ERRCNT;

   serfmem_emu dut (
      .CLKCMS (CLKCMS),
      .RST_B  (RST_B),
      .SCK    (SCK),
      .CS_B   (CS_B),
      .SI     (SI),
      .WP_B   (WP_B),
      .FRST_B (FRST_B),
      .SO     (SO),
      .SO_OE  (SO_OE),
      .BUSY   (BUSY),
      .ERRCNT (ERRCNT)
   );

   always #5 CLKCMS = ~CLKCMS;

   int cyc = 0;
   always @(posedge CLKCMS) cyc++;

   int         checks = 0, failures = 0;
   logic [7:0] mem_m [64];
   int         errcnt_m = 0;
   bit         busy_m = 1'b0;
   int         busy_c0 = 0, last_desel = 0;
   logic       so_q[$], oe_q[$];
   logic [7:0] pd[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] exp_err();
      if (!ERR_EN) return 8'h00;
      return (errcnt_m > 255) ? 8'hFF : 8'(errcnt_m);
   endfunction

   function automatic logic [7:0] get_byte(input int start);
      logic [7:0] b;
      for (int j = 0; j < 8; j++) b[7-j] = so_q[start+j];
      return b;
   endfunction

   task automatic bit_x(input logic si);
      SI = si; SCK = 1'b1;
      @(negedge CLKCMS); @(negedge CLKCMS);
      SCK = 1'b0;
      @(negedge CLKCMS);
      so_q.push_back(SO); oe_q.push_back(SO_OE);
      @(negedge CLKCMS);
   endtask

   task automatic send_byte(input logic [7:0] b);
      for (int i = 7; i >= 0; i--) bit_x(b[i]);
   endtask

   task automatic cs_low();
      so_q.delete(); oe_q.delete();
      CS_B = 1'b0;
      @(negedge CLKCMS); @(negedge CLKCMS);
   endtask

   task automatic deselect();
      CS_B = 1'b1;
      @(negedge CLKCMS);
      last_desel = cyc;
      check("deselect_oe", {31'b0, SO_OE}, 0);
      @(negedge CLKCMS);
   endtask

   task automatic send_addr(input logic [23:0] a);
      send_byte(a[23:16]); send_byte(a[15:8]); send_byte(a[7:0]);
   endtask

   // oe must be low before sample index `first` and high from it on
   task automatic check_oe(input string tag, input int first);
      int bad = 0;
      for (int i = 0; i < oe_q.size(); i++)
         if (oe_q[i] !== ((first >= 0) && (i >= first))) bad++;
      check(tag, bad, 0);
   endtask

   task automatic do_read(input string tag, input logic [23:0] a, input int n);
      cs_low(); send_byte(8'h03); send_addr(a);
      for (int i = 0; i < n * 8 - 1; i++) bit_x(1'($urandom_range(0, 1)));
      check_oe({tag, "_oe"}, 31);
      for (int k = 0; k < n; k++)
         check(tag, get_byte(31 + 8 * k), busy_m ? 8'hFF : mem_m[(int'(a) + k) % 64]);
      deselect();
   endtask

   task automatic do_status(input string tag);
      logic [7:0] e;
      e = {~busy_m, WP_B, 6'b000000};
      cs_low(); send_byte(8'hD7);
      for (int i = 0; i < 15; i++) bit_x(1'($urandom_range(0, 1)));
      check_oe({tag, "_oe"}, 7);
      check(tag, get_byte(7), e);
      check({tag, "_rep"}, get_byte(15), e);
      deselect();
   endtask

   task automatic do_prog(input logic [23:0] a);
      bit blk;
      blk = busy_m;
      cs_low(); send_byte(8'h82); send_addr(a);
      foreach (pd[k]) send_byte(pd[k]);
      deselect();
      if (blk) errcnt_m++;
      else if (pd.size() == 0) errcnt_m++;
      else begin
         if (WP_B) foreach (pd[k]) mem_m[(int'(a) + k) % 64] = pd[k];
         busy_m = 1'b1;
         busy_c0 = last_desel;
      end
   endtask

   task automatic wait_busy(input string tag);
      int n = 0;
      while (BUSY === 1'b1 && n < 2000) begin @(negedge CLKCMS); n++; end
      check({tag, "_done"}, {31'b0, BUSY}, 0);
      check({tag, "_len"}, cyc - busy_c0, PROG_CYCLES);
      busy_m = 1'b0;
   endtask

   task automatic frst_pulse();
      FRST_B = 1'b0;
      @(negedge CLKCMS);
      check("frst_oe", {31'b0, SO_OE}, 0);
      check("frst_busy", {31'b0, BUSY}, 0);
      FRST_B = 1'b1;
      busy_m = 1'b0;
      @(negedge CLKCMS);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [23:0] a;
      int          n;
      foreach (mem_m[i]) mem_m[i] = 8'hFF;
      repeat (3) @(negedge CLKCMS);
      RST_B = 1'b1;
      @(negedge CLKCMS);
      check("rst_so", {31'b0, SO}, 0);
      check("rst_oe", {31'b0, SO_OE}, 0);
      check("rst_busy", {31'b0, BUSY}, 0);
      check("rst_errcnt", ERRCNT, 0);

      // erased array after reset
      do_read("rd_erased", 24'h000000, 2);

      // program across the top of the array
      WP_B = 1'b1;
      pd.delete(); pd.push_back(8'hA5); pd.push_back(8'h5A); pd.push_back(8'hC3);
      do_prog(24'h00003E);
      wait_busy("busy_prog");
      do_read("rd_wrap", 24'h00003E, 3);

      // write-protected program, status busy/idle
      WP_B = 1'b0;
      pd.delete(); pd.push_back(8'h12);
      do_prog(24'h000010);
      do_status("stat_busy");
      wait_busy("busy_wp");
      do_status("stat_idle");
      WP_B = 1'b1;
      do_read("rd_wp", 24'h000010, 1);

      // abort, unknown opcode, program while busy
      cs_low();
      for (int i = 0; i < 5; i++) bit_x(1'b1);
      deselect();
      errcnt_m++;
      check("err_abort", ERRCNT, exp_err());
      cs_low(); send_byte(8'h55);
      for (int i = 0; i < 8; i++) bit_x(1'b0);
      check_oe("ignore_oe", -1);
      deselect();
      errcnt_m++;
      check("err_unknown", ERRCNT, exp_err());
      pd.delete(); pd.push_back(8'h77);
      do_prog(24'h000005);
      pd.delete(); pd.push_back(8'h88);
      do_prog(24'h000006);
      check("err_progbusy", ERRCNT, exp_err());
      wait_busy("busy_norestart");
      do_read("rd_blocked", 24'h000005, 2);

      // randomised traffic against the model
      for (int it = 0; it < 10; it++) begin
         a = 24'($urandom);
         n = $urandom_range(1, 3);
         case ($urandom_range(0, 2))
            0: begin
               WP_B = ($urandom_range(0, 3) != 0);
               pd.delete();
               for (int k = 0; k < n; k++) pd.push_back(8'($urandom));
               do_prog(a);
               if ($urandom_range(0, 1) == 1) do_read("rd_during_busy", a, 2);
               wait_busy("busy_rand");
            end
            1: do_read("rd_rand", a, n);
            default: begin
               WP_B = 1'($urandom_range(0, 1));
               do_status("stat_rand");
            end
         endcase
      end
      WP_B = 1'b1;

      // FRST_B while busy, mid-read and mid-program
      pd.delete(); pd.push_back(8'($urandom)); pd.push_back(8'($urandom));
      do_prog(24'h000020);
      repeat (10) @(negedge CLKCMS);
      frst_pulse();
      cs_low(); send_byte(8'h03); send_addr(24'h000020);
      for (int i = 0; i < 8; i++) bit_x(1'b0);
      check("rd_oe_before_frst", {31'b0, SO_OE}, 1);
      frst_pulse();
      deselect();
      errcnt_m++;
      cs_low(); send_byte(8'h82); send_addr(24'h000028);
      for (int k = 0; k < 2; k++) begin
         mem_m[40 + k] = 8'($urandom);
         send_byte(mem_m[40 + k]);
      end
      frst_pulse();
      deselect();
      errcnt_m++;
      check("frst_prog_nobusy", {31'b0, BUSY}, 0);
      check("err_frst", ERRCNT, exp_err());
      do_read("rd_after_frst", 24'h000020, 2);
      do_read("rd_frst_prog", 24'h000028, 3);

      // RST_B mid-program restores everything
      cs_low(); send_byte(8'h82); send_addr(24'h000030); send_byte(8'h3C);
      RST_B = 1'b0;
      @(negedge CLKCMS);
      check("rst_mid_oe", {31'b0, SO_OE}, 0);
      check("rst_mid_busy", {31'b0, BUSY}, 0);
      check("rst_mid_errcnt", ERRCNT, 0);
      RST_B = 1'b1;
      foreach (mem_m[i]) mem_m[i] = 8'hFF;
      errcnt_m = 0;
      busy_m = 1'b0;
      @(negedge CLKCMS);
      deselect();
      errcnt_m++;
      check("err_after_rst", ERRCNT, exp_err());
      do_read("rd_after_rst", 24'h000020, 2);
      do_read("rd_after_rst30", 24'h000030, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
